dif_chain_n: RTL and testbench

Parametrised successor to the fixed three-order differentiator in the weld neck-detection chain (ADC -> Kalman -> sample period -> differentiator -> neck judge).
- Merges sample-period decimation with an N-order backward-difference chain.
- Adds saturating arithmetic, per-order validity (warm-up) and a synchronous clear.
- Feeds the neck-judge stage with one packed bus of all orders.

---
 rtl/dif_pkg.sv | 40 ++++
 rtl/dif_stage.sv | 52 +++++
 rtl/dif_chain_n.sv | 110 +++++++++++
 tb/tb_dif_chain_n.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dif_pkg.sv
// Shared constants and arithmetic helpers for the N-order backward-difference chain.
package dif_pkg;

    localparam int MAX_ORDER  = 4;
    localparam int DEF_DATA_W = 13;
    localparam int PCNT_W     = 3;

    typedef struct packed {
        logic signed [31:0] val;
        logic               ovf;
    } sat_res_t;

    // Operands arrive sign-extended to 32 bits; the difference is clamped to a w-bit signed range.
    function automatic sat_res_t sat_sub(input logic signed [31:0] a,
                                         input logic signed [31:0] b,
                                         input int                 w);
        logic signed [32:0] diff;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sat_res_t           r;
        diff  = {a[31], a} - {b[31], b};
        hi    = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo    = -(33'sd1 <<< (w - 1));
        r.val = diff[31:0];
        r.ovf = 1'b0;
        if (diff > hi) begin
            r.val = hi[31:0];
            r.ovf = 1'b1;
        end else if (diff < lo) begin
            r.val = lo[31:0];
            r.ovf = 1'b1;
        end
        return r;
    endfunction

    function automatic int slice_lo(input int k, input int w);
        return (k - 1) * w;
    endfunction

endpackage

// File: rtl/dif_stage.sv
// One difference order: keeps the previous lower-order value and emits the clamped difference.
module dif_stage
    import dif_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int K      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     take,
    input  logic [PCNT_W-1:0]        pcnt,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] dout,
    output logic signed [DATA_W-1:0] dgate,
    output logic                     sat
);

    logic signed [DATA_W-1:0] hist_q;
    logic signed [DATA_W-1:0] hist_d;
    sat_res_t                 res;
    logic                     valid;
    logic                     unused_hi;

    always_comb begin
        res   = sat_sub({{(32-DATA_W){din[DATA_W-1]}}, din},
                        {{(32-DATA_W){hist_q[DATA_W-1]}}, hist_q}, DATA_W);
        dout  = res.val[DATA_W-1:0];
        valid = (int'(pcnt) >= K);
        // History keeps the unforced value so warm-up gating never corrupts later orders.
        dgate = valid ? dout : '0;
        sat   = valid & res.ovf;
        if (clear) begin
            hist_d = '0;
        end else if (take) begin
            hist_d = din;
        end else begin
            hist_d = hist_q;
        end
    end

    assign unused_hi = ^res.val[31:DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/dif_chain_n.sv
// Decimating N-order differentiator feeding the neck judge with one packed bus of all orders.
module dif_chain_n
    import dif_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ORDER  = 3,
    parameter int DECIM  = 1,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic signed [DATA_W-1:0]  in_data,
    output logic                      out_valid,
    output logic [ORDER*DATA_W-1:0]   dif_data,
    output logic [ORDER-1:0]          sat_flag,
    output logic                      primed
);

    logic signed [DATA_W-1:0] chain [0:ORDER];
    logic [ORDER*DATA_W-1:0]  dgate_w;
    logic [ORDER-1:0]         sat_w;
    logic                     take;
    logic                     unused_tail;

    logic [CNT_W-1:0]         dcnt_q, dcnt_d;
    logic [PCNT_W-1:0]        pcnt_q, pcnt_d;
    logic                     out_valid_q, out_valid_d;
    logic [ORDER*DATA_W-1:0]  dif_q, dif_d;
    logic [ORDER-1:0]         sat_q, sat_d;
    logic                     primed_q, primed_d;

    assign chain[0]    = in_data;
    assign unused_tail = ^chain[ORDER];
    assign take        = in_valid & ~clear & (dcnt_q == CNT_W'(DECIM - 1));

    for (genvar k = 1; k <= ORDER; k++) begin : g_stage
        localparam int LO = slice_lo(k, DATA_W);
        dif_stage #(
            .DATA_W (DATA_W),
            .K      (k)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .clear (clear),
            .take  (take),
            .pcnt  (pcnt_q),
            .din   (chain[k-1]),
            .dout  (chain[k]),
            .dgate (dgate_w[LO +: DATA_W]),
            .sat   (sat_w[k-1])
        );
    end

    always_comb begin
        dcnt_d      = dcnt_q;
        pcnt_d      = pcnt_q;
        out_valid_d = 1'b0;
        dif_d       = dif_q;
        sat_d       = sat_q;
        primed_d    = primed_q;
        if (clear) begin
            dcnt_d   = '0;
            pcnt_d   = '0;
            dif_d    = '0;
            sat_d    = '0;
            primed_d = 1'b0;
        end else begin
            if (in_valid) begin
                dcnt_d = take ? '0 : dcnt_q + 1'b1;
            end
            if (take) begin
                out_valid_d = 1'b1;
                dif_d       = dgate_w;
                sat_d       = sat_w;
                // pcnt already at ORDER means this output carries the (ORDER+1)-th taken sample.
                if (pcnt_q == PCNT_W'(ORDER)) begin
                    primed_d = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt_q      <= '0;
            pcnt_q      <= '0;
            out_valid_q <= 1'b0;
            dif_q       <= '0;
            sat_q       <= '0;
            primed_q    <= 1'b0;
        end else begin
            dcnt_q      <= dcnt_d;
            pcnt_q      <= pcnt_d;
            out_valid_q <= out_valid_d;
            dif_q       <= dif_d;
            sat_q       <= sat_d;
            primed_q    <= primed_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dif_data  = dif_q;
    assign sat_flag  = sat_q;
    assign primed    = primed_q;

endmodule

// File: tb/tb_dif_chain_n.sv
// Directed bench for dif_chain_n: one DECIM=1 instance and one DECIM=4 instance.
module tb_dif_chain_n;

    localparam int DW = 13;
    localparam int OR = 3;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              iv_a;
    logic              iv_b;
    logic signed [DW-1:0] in_data;

    logic              ov_a, ov_b;
    logic [OR*DW-1:0]  dif_a, dif_b;
    logic [OR-1:0]     sat_a, sat_b;
    logic              pr_a, pr_b;

    int n_chk;
    int n_pass;

    dif_chain_n #(.DATA_W(DW), .ORDER(OR), .DECIM(1), .CNT_W(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (iv_a),
        .in_data   (in_data),
        .out_valid (ov_a),
        .dif_data  (dif_a),
        .sat_flag  (sat_a),
        .primed    (pr_a)
    );

    dif_chain_n #(.DATA_W(DW), .ORDER(OR), .DECIM(4), .CNT_W(16)) u_dec (
        .clk       (clk),
        .rst       (rst),
        .clear     (1'b0),
        .in_valid  (iv_b),
        .in_data   (in_data),
        .out_valid (ov_b),
        .dif_data  (dif_b),
        .sat_flag  (sat_b),
        .primed    (pr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int da(input int k);
        logic signed [DW-1:0] s;
        s = dif_a[(k-1)*DW +: DW];
        return int'(s);
    endfunction

    function automatic int db(input int k);
        logic signed [DW-1:0] s;
        s = dif_b[(k-1)*DW +: DW];
        return int'(s);
    endfunction

    task automatic send(input bit sel, input int d);
        @(negedge clk);
        in_data = d[DW-1:0];
        if (sel) iv_b = 1'b1;
        else     iv_a = 1'b1;
        @(posedge clk);
        #1;
        iv_a = 1'b0;
        iv_b = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic ramp_checks(input string pfx);
        int exp_d1 [5];
        exp_d1 = '{0, 10, 10, 10, 10};
        for (int i = 0; i < 5; i++) begin
            send(1'b0, i * 10);
            chk({pfx, " ov"}, ov_a, 1);
            chk({pfx, " d1"}, da(1), exp_d1[i]);
            chk({pfx, " d2"}, da(2), 0);
            chk({pfx, " d3"}, da(3), 0);
            chk({pfx, " sat"}, sat_a, 0);
            chk({pfx, " primed"}, pr_a, (i >= 3) ? 1 : 0);
        end
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst     = 1'b1;
        clear   = 1'b0;
        iv_a    = 1'b0;
        iv_b    = 1'b0;
        in_data = '0;
        #12;
        chk("rst ov", ov_a, 0);
        chk("rst dif", dif_a, 0);
        chk("rst sat", sat_a, 0);
        chk("rst primed", pr_a, 0);
        @(negedge clk);
        rst = 1'b0;

        // Ramp
        ramp_checks("ramp");
        @(posedge clk);
        #1;
        chk("idle ov", ov_a, 0);
        chk("idle hold d1", da(1), 10);
        chk("idle primed", pr_a, 1);

        // Quadratic
        do_clear();
        chk("clr primed", pr_a, 0);
        for (int n = 0; n < 5; n++) begin
            send(1'b0, n * n);
            if (n == 2) begin
                chk("quad n2 d1", da(1), 3);
                chk("quad n2 d2", da(2), 2);
                chk("quad n2 d3 warm", da(3), 0);
            end
        end
        chk("quad d1", da(1), 7);
        chk("quad d2", da(2), 2);
        chk("quad d3", da(3), 0);
        chk("quad sat", sat_a, 0);

        // Saturation
        do_clear();
        send(1'b0, -4096);
        chk("satA d1", da(1), 0);
        send(1'b0, 4095);
        chk("satB d1", da(1), 4095);
        chk("satB flag", sat_a, 1);
        chk("satB d2 warm", da(2), 0);
        send(1'b0, 4095);
        chk("satC d1", da(1), 0);
        chk("satC d2", da(2), -4095);
        chk("satC flag", sat_a, 0);
        chk("satC primed", pr_a, 0);

        // Decimation by 4 on the second instance
        for (int i = 0; i < 8; i++) begin
            send(1'b1, i);
            chk($sformatf("dec ov%0d", i), ov_b, (i == 3 || i == 7) ? 1 : 0);
            if (i == 3) chk("dec first d1", db(1), 0);
        end
        chk("dec d1", db(1), 4);
        chk("dec primed", pr_b, 0);

        // Clear colliding with a sample after priming
        send(1'b0, 4095);
        chk("pre-clr primed", pr_a, 1);
        @(negedge clk);
        clear   = 1'b1;
        iv_a    = 1'b1;
        in_data = 13'sd100;
        @(posedge clk);
        #1;
        clear = 1'b0;
        iv_a  = 1'b0;
        chk("clr ov", ov_a, 0);
        chk("clr primed0", pr_a, 0);
        chk("clr dif", dif_a, 0);
        chk("clr sat", sat_a, 0);
        send(1'b0, 50);
        chk("post-clr ov", ov_a, 1);
        chk("post-clr d1", da(1), 0);
        send(1'b0, 70);
        chk("post-clr2 d1", da(1), 20);
        chk("post-clr2 d2", da(2), 0);

        // Asynchronous reset mid-stream
        send(1'b0, 0);
        send(1'b0, 10);
        chk("pre-rst primed", pr_a, 1);
        chk("pre-rst ov", ov_a, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst ov", ov_a, 0);
        chk("arst dif", dif_a, 0);
        chk("arst primed", pr_a, 0);
        chk("arst dec dif", dif_b, 0);
        @(negedge clk);
        rst = 1'b0;
        ramp_checks("reramp");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
